wb_burst_slave: RTL and testbench

// - Single-clock Wishbone slave responder backed by an internal word RAM; the far end of a Wishbone master port (e.g. bridge master side).
// - Answers classic cycles with programmable wait states and linear incremental bursts (CTI 3'b010, 3'b111) at one beat per cycle.
// - Byte-lane writes via SEL; used as a sample/scratch buffer and as a bench target for bridge and master ports.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_slv_ram.sv | 26 ++
 rtl/wb_burst_slave.sv | 140 ++++++++++++++
 tb/tb_wb_burst_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle type identifiers and the slave FSM state encoding.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_ACK   = 2'd2;
  localparam state_t ST_BURST = 2'd3;

  function automatic logic is_burst_cti(input logic [2:0] cti);
    return (cti == CTI_INCR) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wb_slv_ram.sv
// DEPTH x 32 single-port synchronous RAM with per-byte write enables and a registered read.
module wb_slv_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Read-first: a write cycle returns the word's old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_burst_slave.sv
// Wishbone slave with programmable wait states and zero-bubble incrementing bursts over a word RAM.
// Optional WB_SLV_ERR_EN: out-of-range accesses terminate with ERR instead of ACK.
module wb_burst_slave
  import wb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t        state;
  state_t        state_next;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_next;
  logic          we_q;
  logic          hi_q;

  logic          req;
  logic [AW-1:0] req_idx;
  logic          req_hi;
  logic          oor;
  logic          beat;
  logic          err_beat;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  logic          unused_adr;

  assign req        = wbs_cyc_i & wbs_stb_i;
  assign req_idx    = wbs_adr_i[AW+1:2];
  assign req_hi     = |wbs_adr_i[31:AW+2];
  assign oor        = hi_q | ({1'b0, addr_q} >= DEPTH_LIM);
  assign unused_adr = ^wbs_adr_i[1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req) state_next = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        if (!req)               state_next = ST_IDLE;
        else if (wait_cnt == 0) state_next = ST_ACK;
      end
      ST_ACK: begin
        if (beat && !err_beat && (wbs_cti_i == CTI_INCR)) state_next = ST_BURST;
        else                                              state_next = ST_IDLE;
      end
      ST_BURST: begin
        // stb low with cyc held is a pause: hold position and stay in the burst.
        if (!wbs_cyc_i) begin
          state_next = ST_IDLE;
        end else if (wbs_stb_i) begin
          if (!beat || err_beat || (wbs_cti_i == CTI_EOB)) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      ST_ACK:   beat = req;
      ST_BURST: beat = req && (wbs_we_i == we_q) && is_burst_cti(wbs_cti_i);
      default:  beat = 1'b0;
    endcase
`ifdef WB_SLV_ERR_EN
    err_beat = beat & oor;
`else
    err_beat = 1'b0;
`endif
    wbs_ack_o = beat & ~err_beat;
    wbs_err_o = err_beat;
    wbs_dat_o = (wbs_ack_o && !we_q && !oor) ? ram_rdata : 32'h0;
  end

  // The RAM is always read at the counter's next value so the following beat's word is ready without a bubble.
  always_comb begin
    addr_next = addr_q;
    if ((state == ST_IDLE) && req) addr_next = req_idx;
    else if (beat)                 addr_next = addr_q + 1'b1;
    ram_we   = beat & we_q & ~oor & ~sys_rst;
    ram_addr = ram_we ? addr_q : addr_next;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      addr_q <= addr_next;
      if ((state == ST_IDLE) && req) begin
        wait_cnt <= WAIT_LOAD;
        we_q     <= wbs_we_i;
        hi_q     <= req_hi;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  wb_slv_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (sys_clk),
    .we    (ram_we),
    .be    (wbs_sel_i),
    .addr  (ram_addr),
    .wdata (wbs_dat_i),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_wb_burst_slave.sv
// Randomized bench for wb_burst_slave against a word-array model of the slave's documented behaviour.
// Define WB_SLV_ERR_EN to check the error-terminating build.
module tb_wb_burst_slave;
  import wb_pkg::*;

  localparam int DEPTH       = 64;
  localparam int WAIT_STATES = 1;
`ifdef WB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic [2:0]  wbs_cti_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  logic [31:0] model [DEPTH];
  int          test_count = 0;
  int          fail_count = 0;

  wb_burst_slave #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (WAIT_STATES)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_i (wbs_sel_i),
    .wbs_cti_i (wbs_cti_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One classic cycle: inputs change just after a rising edge, outputs are sampled on falling edges.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] adr,
                               input logic [31:0] wd, input logic [3:0] sel, output logic [31:0] rd);
    int   lat;
    int   idx;
    bit   oor;
    logic got_ack;
    logic got_err;
    idx     = int'(adr[31:2]);
    oor     = (idx >= DEPTH);
    lat     = -1;
    got_ack = 1'b0;
    got_err = 1'b0;
    rd      = 32'h0;
    @(posedge sys_clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr;
    wbs_dat_i = wd;   wbs_sel_i = sel;  wbs_cti_i = CTI_CLASSIC;
    for (int n = 0; n <= 20; n++) begin
      @(negedge sys_clk);
      if (wbs_ack_o || wbs_err_o) begin
        lat = n; got_ack = wbs_ack_o; got_err = wbs_err_o; rd = wbs_dat_o;
        break;
      end
    end
    @(posedge sys_clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    checkOutput($sformatf("%s latency", tag), 32'(lat), 32'(WAIT_STATES + 1));
    checkOutput($sformatf("%s ack", tag), {31'b0, got_ack}, {31'b0, !(ERR_EN && oor)});
    checkOutput($sformatf("%s err", tag), {31'b0, got_err}, {31'b0, ERR_EN && oor});
    if (!we)      checkOutput($sformatf("%s rdata", tag), rd, oor ? 32'h0 : model[idx]);
    else if (!oor) model[idx] = merge(model[idx], wd, sel);
  endtask

  // Linear burst of n beats from word 'start'; optional stb gap before beat gap_at and cyc abort before beat abort_at.
  task automatic burstStimulus(input string tag, input logic we, input int start, input int n,
                               input int gap_at, input int gap_len, input int abort_at);
    logic [31:0] wd;
    logic [3:0]  sl;
    int          idx;
    int          lat;
    wd = $urandom;
    sl = we ? 4'($urandom_range(1, 15)) : 4'hF;
    @(posedge sys_clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = 32'(start * 4);
    wbs_dat_i = wd;   wbs_sel_i = sl;   wbs_cti_i = (n == 1) ? CTI_EOB : CTI_INCR;
    lat = -1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge sys_clk);
      if (wbs_ack_o || wbs_err_o) begin lat = c; break; end
    end
    checkOutput($sformatf("%s first latency", tag), 32'(lat), 32'(WAIT_STATES + 1));
    for (int b = 0; b < n; b++) begin
      idx = (start + b) % DEPTH;
      if (b > 0) begin
        @(negedge sys_clk);
        checkOutput($sformatf("%s beat%0d ack", tag, b), {31'b0, wbs_ack_o}, 32'h1);
      end
      if (!we) checkOutput($sformatf("%s beat%0d data", tag, b), wbs_dat_o, model[idx]);
      else     model[idx] = merge(model[idx], wd, sl);
      @(posedge sys_clk); #1;
      if (b == n - 1) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_cti_i = CTI_CLASSIC;
      end else if (b + 1 == abort_at) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_cti_i = CTI_CLASSIC;
        @(negedge sys_clk);
        checkOutput($sformatf("%s abort ack", tag), {31'b0, wbs_ack_o}, 32'h0);
        break;
      end else begin
        if (b + 1 == gap_at) begin
          wbs_stb_i = 1'b0;
          for (int g = 0; g < gap_len; g++) begin
            @(negedge sys_clk);
            checkOutput($sformatf("%s gap%0d ack", tag, g), {31'b0, wbs_ack_o}, 32'h0);
            @(posedge sys_clk); #1;
          end
          wbs_stb_i = 1'b1;
        end
        wd = $urandom;
        sl = we ? 4'($urandom_range(1, 15)) : 4'hF;
        wbs_dat_i = wd; wbs_sel_i = sl;
        wbs_adr_i = 32'(((start + b + 1) % DEPTH) * 4);
        wbs_cti_i = (b + 1 == n - 1) ? CTI_EOB : CTI_INCR;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          w0;
    sys_rst   = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0;
    wbs_dat_i = 32'h0; wbs_sel_i = 4'hF; wbs_cti_i = CTI_CLASSIC;

    for (int i = 0; i < 2; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput($sformatf("reset%0d ack", i), {31'b0, wbs_ack_o}, 32'h0);
      checkOutput($sformatf("reset%0d err", i), {31'b0, wbs_err_o}, 32'h0);
      checkOutput($sformatf("reset%0d dat", i), wbs_dat_o, 32'h0);
    end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

    // RAM is not cleared by reset, so the word under test is written before its data is compared.
    applyStimulus("post-reset write", 1'b1, 32'h0, 32'hA5A5_0F0F, 4'hF, rd);
    applyStimulus("post-reset read", 1'b0, 32'h0, 32'h0, 4'hF, rd);

    for (int i = 0; i < DEPTH; i++)
      applyStimulus($sformatf("preload%0d", i), 1'b1, 32'(i * 4), $urandom, 4'hF, rd);

    applyStimulus("fill 0x10", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd);
    applyStimulus("sel write", 1'b1, 32'h10, 32'h1234_5678, 4'b0101, rd);
    applyStimulus("sel read", 1'b0, 32'h10, 32'h0, 4'hF, rd);
    checkOutput("sel merge", rd, 32'hFF34_FF78);

    burstStimulus("burst rd 8", 1'b0, 8, 4, -1, 0, -1);
    applyStimulus("after burst", 1'b0, 32'h24, 32'h0, 4'hF, rd);

    burstStimulus("wrap wr", 1'b1, DEPTH - 2, 4, -1, 0, -1);
    applyStimulus("wrap rd62", 1'b0, 32'((DEPTH - 2) * 4), 32'h0, 4'hF, rd);
    applyStimulus("wrap rd63", 1'b0, 32'((DEPTH - 1) * 4), 32'h0, 4'hF, rd);
    applyStimulus("wrap rd0", 1'b0, 32'h0, 32'h0, 4'hF, rd);
    applyStimulus("wrap rd1", 1'b0, 32'h4, 32'h0, 4'hF, rd);

    burstStimulus("gap rd", 1'b0, 20, 5, 2, 3, -1);
    burstStimulus("gap wr", 1'b1, 30, 5, 3, 2, -1);
    burstStimulus("abort rd", 1'b0, 40, 6, -1, 0, 3);
    applyStimulus("after abort", 1'b0, 32'h14, 32'h0, 4'hF, rd);

    applyStimulus("oor write", 1'b1, 32'h100, $urandom, 4'hF, rd);
    applyStimulus("oor read", 1'b0, 32'h100, 32'h0, 4'hF, rd);
    applyStimulus("oor alias", 1'b0, 32'h0, 32'h0, 4'hF, rd);

    for (int t = 0; t < 60; t++) begin
      w0 = $urandom_range(0, 3);
      if (w0 == 0) begin
        applyStimulus($sformatf("rnd%0d wr", t), 1'b1,
                      32'($urandom_range(0, DEPTH - 1) * 4), $urandom, 4'($urandom_range(1, 15)), rd);
      end else if (w0 == 1) begin
        applyStimulus($sformatf("rnd%0d rd", t), 1'b0,
                      32'($urandom_range(0, 2 * DEPTH - 1) * 4), 32'h0, 4'hF, rd);
      end else begin
        burstStimulus($sformatf("rnd%0d burst", t), 1'(w0 == 2), $urandom_range(0, DEPTH - 1),
                      $urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(0, 3), -1);
      end
    end

    for (int i = 0; i < DEPTH; i++)
      applyStimulus($sformatf("final%0d", i), 1'b0, 32'(i * 4), 32'h0, 4'hF, rd);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
